// File: rtl/reward_pkg.sv
// Reward subsystem shared types: reward type codes, scheduler FSM encoding
// and the helper that decides whether a generated type is a real reward.
package reward_pkg;

  localparam logic [2:0] REW_NONE   = 3'd0;
  localparam logic [2:0] REW_INV    = 3'd1;
  localparam logic [2:0] REW_FAST   = 3'd2;
  localparam logic [2:0] REW_FROZEN = 3'd3;
  localparam logic [2:0] REW_LASER  = 3'd4;

  typedef enum logic [1:0] {
    ST_COOLDOWN = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_PLACED   = 2'd2
  } state_e;

  function automatic logic is_reward_type(input logic [2:0] t);
    return (t >= REW_INV) && (t <= REW_LASER);
  endfunction

endpackage

// File: rtl/reward_effect_timer.sv
// One effect duration timer: loads DURATION on grant, counts ticks down to 0.
// Priority clear > load > tick; active is high exactly while the count is nonzero.
module reward_effect_timer #(
  parameter int CNT_W    = 6,
  parameter int DURATION = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             active
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = CNT_W'(DURATION);
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign active = (count_q != '0);

endmodule

// File: rtl/reward_scheduler.sv
// Paces reward spawns (req/ack), tracks reward lifetime and turns pickups into effect grants.
// spawn_ack -> reward_valid 1 cycle; pickup -> effect/addtime/reward_taken 1 cycle.
module reward_scheduler
  import reward_pkg::*;
#(
  parameter int DURATION  = 20,
  parameter int SPAWN_GAP = 8,
  parameter int LIFETIME  = 40,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             enable,
  input  logic             mode_classic,
  input  logic             mode_infinity,
  output logic             spawn_req,
  input  logic             spawn_ack,
  input  logic [2:0]       spawn_type,
  input  logic             pickup,
  output logic             reward_valid,
  output logic             reward_taken,
  output logic             reward_invincible,
  output logic             reward_addtime,
  output logic             reward_faster,
  output logic             reward_frozen,
  output logic             reward_laser,
  output logic [CNT_W-1:0] remain_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d, life_q, life_d;
  logic [2:0]       cur_type_q, cur_type_d, last_type_q, last_type_d;
  logic             spawn_req_q, spawn_req_d;
  logic             reward_valid_q, reward_valid_d;
  logic             reward_taken_q, reward_taken_d;
  logic             addtime_q, addtime_d;
  logic             grant;
  logic [3:0]       load;
  logic [3:0]       active;
  logic [CNT_W-1:0] cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_COOLDOWN;
      gap_q          <= CNT_W'(SPAWN_GAP);
      life_q         <= '0;
      cur_type_q     <= REW_NONE;
      last_type_q    <= REW_NONE;
      spawn_req_q    <= 1'b0;
      reward_valid_q <= 1'b0;
      reward_taken_q <= 1'b0;
      addtime_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      life_q         <= life_d;
      cur_type_q     <= cur_type_d;
      last_type_q    <= last_type_d;
      spawn_req_q    <= spawn_req_d;
      reward_valid_q <= reward_valid_d;
      reward_taken_q <= reward_taken_d;
      addtime_q      <= addtime_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    life_d     = life_q;
    cur_type_d = cur_type_q;
    if (!enable) begin
      state_d    = ST_COOLDOWN;
      gap_d      = CNT_W'(SPAWN_GAP);
      life_d     = '0;
      cur_type_d = REW_NONE;
    end else begin
      unique case (state_q)
        ST_COOLDOWN: begin
          if (gap_q == '0) begin
            state_d = ST_REQUEST;
          end else if (tick) begin
            gap_d = gap_q - 1'b1;
            if (gap_q == CNT_W'(1)) state_d = ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (spawn_ack) begin
            cur_type_d = spawn_type;
            if (is_reward_type(spawn_type)) begin
              state_d = ST_PLACED;
              life_d  = CNT_W'(LIFETIME);
            end else begin
              state_d = ST_COOLDOWN;
              gap_d   = CNT_W'(SPAWN_GAP);
            end
          end
        end
        ST_PLACED: begin
          // Pickup is checked first so a pickup on the expiring tick still grants.
          if (pickup || (tick && (life_q <= CNT_W'(1)))) begin
            state_d = ST_COOLDOWN;
            gap_d   = CNT_W'(SPAWN_GAP);
            life_d  = '0;
          end else if (tick) begin
            life_d = life_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_COOLDOWN;
          gap_d   = CNT_W'(SPAWN_GAP);
        end
      endcase
    end
  end

  always_comb begin
    grant          = enable && (state_q == ST_PLACED) && pickup;
    spawn_req_d    = enable && (state_d == ST_REQUEST);
    reward_valid_d = enable && (state_d == ST_PLACED);
    reward_taken_d = enable &&
                     (((state_q == ST_REQUEST) && spawn_ack && !is_reward_type(spawn_type)) ||
                      ((state_q == ST_PLACED) && (state_d == ST_COOLDOWN)));
    load[0]   = grant && (cur_type_q == REW_INV) && mode_classic;
    load[1]   = grant && (cur_type_q == REW_FAST);
    load[2]   = grant && (cur_type_q == REW_FROZEN);
    load[3]   = grant && (cur_type_q == REW_LASER);
    addtime_d = grant && (cur_type_q == REW_INV) && !mode_classic && mode_infinity;
    last_type_d = last_type_q;
    if (!enable)      last_type_d = REW_NONE;
    else if (|load)   last_type_d = cur_type_q;
  end

  for (genvar i = 0; i < 4; i++) begin : g_timer
    reward_effect_timer #(
      .CNT_W    (CNT_W),
      .DURATION (DURATION)
    ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!enable),
      .load   (load[i]),
      .tick   (tick),
      .count  (cnt[i]),
      .active (active[i])
    );
  end

  always_comb begin
    unique case (last_type_q)
      REW_INV:    remain_cnt = cnt[0];
      REW_FAST:   remain_cnt = cnt[1];
      REW_FROZEN: remain_cnt = cnt[2];
      REW_LASER:  remain_cnt = cnt[3];
      default:    remain_cnt = '0;
    endcase
  end

  assign spawn_req         = spawn_req_q;
  assign reward_valid      = reward_valid_q;
  assign reward_taken      = reward_taken_q;
  assign reward_addtime    = addtime_q;
  assign reward_invincible = active[0];
  assign reward_faster     = active[1];
  assign reward_frozen     = active[2];
  assign reward_laser      = active[3];

endmodule

// File: tb/tb_reward_scheduler.sv
// Directed bench for reward_scheduler with hand-computed expectations.
module tb_reward_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, tick, enable, mode_classic, mode_infinity;
  logic       spawn_req, spawn_ack, pickup;
  logic [2:0] spawn_type;
  logic       reward_valid, reward_taken, reward_invincible, reward_addtime;
  logic       reward_faster, reward_frozen, reward_laser;
  logic [5:0] remain_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reward_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tick              (tick),
    .enable            (enable),
    .mode_classic      (mode_classic),
    .mode_infinity     (mode_infinity),
    .spawn_req         (spawn_req),
    .spawn_ack         (spawn_ack),
    .spawn_type        (spawn_type),
    .pickup            (pickup),
    .reward_valid      (reward_valid),
    .reward_taken      (reward_taken),
    .reward_invincible (reward_invincible),
    .reward_addtime    (reward_addtime),
    .reward_faster     (reward_faster),
    .reward_frozen     (reward_frozen),
    .reward_laser      (reward_laser),
    .remain_cnt        (remain_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic ack(input logic [2:0] t);
    spawn_ack  = 1'b1;
    spawn_type = t;
    cyc();
    spawn_ack  = 1'b0;
    spawn_type = 3'd0;
  endtask

  task automatic grab();
    pickup = 1'b1;
    cyc();
    pickup = 1'b0;
  endtask

  function automatic logic [6:0] fx();
    return {reward_invincible, reward_addtime, reward_faster, reward_frozen,
            reward_laser, reward_valid, reward_taken};
  endfunction

  initial begin
    rst_n = 1'b0; tick = 1'b0; enable = 1'b1; mode_classic = 1'b0; mode_infinity = 1'b0;
    spawn_ack = 1'b0; spawn_type = 3'd0; pickup = 1'b0;
    repeat (3) cyc();
    chk("reset_outputs", {25'd0, fx()}, 32'd0);
    chk("reset_req", spawn_req, 1'b0);
    chk("reset_remain", remain_cnt, 6'd0);
    rst_n = 1'b1;
    cyc();

    ticks(7);
    chk("gap_7_no_req", spawn_req, 1'b0);
    ticks(1);
    chk("gap_8_req", spawn_req, 1'b1);
    cyc();
    chk("req_held", spawn_req, 1'b1);
    ack(3'd3);
    chk("ack_valid", reward_valid, 1'b1);
    chk("ack_req_drop", spawn_req, 1'b0);

    ticks(39);
    chk("life_39_valid", reward_valid, 1'b1);
    chk("life_39_taken", reward_taken, 1'b0);
    ticks(1);
    chk("expire_taken", reward_taken, 1'b1);
    chk("expire_valid", reward_valid, 1'b0);
    cyc();
    chk("expire_pulse_end", reward_taken, 1'b0);
    chk("expire_no_effect", {27'd0, reward_invincible, reward_faster, reward_frozen,
                             reward_laser, reward_addtime}, 32'd0);
    ticks(7);
    chk("regap_7_no_req", spawn_req, 1'b0);
    ticks(1);
    chk("regap_8_req", spawn_req, 1'b1);

    ack(3'd2);
    grab();
    chk("fast_on", reward_faster, 1'b1);
    chk("fast_taken", reward_taken, 1'b1);
    chk("fast_valid_off", reward_valid, 1'b0);
    chk("fast_remain20", remain_cnt, 6'd20);
    ticks(19);
    chk("fast_19_on", reward_faster, 1'b1);
    chk("fast_remain1", remain_cnt, 6'd1);
    ticks(1);
    chk("fast_20_off", reward_faster, 1'b0);
    chk("fast_remain0", remain_cnt, 6'd0);
    chk("req_after_fast", spawn_req, 1'b1);

    ack(3'd0);
    chk("type0_taken", reward_taken, 1'b1);
    chk("type0_valid", reward_valid, 1'b0);
    chk("type0_req", spawn_req, 1'b0);
    ticks(8);
    chk("type0_regap_req", spawn_req, 1'b1);

    mode_infinity = 1'b1;
    ack(3'd1);
    grab();
    chk("inf_addtime", reward_addtime, 1'b1);
    chk("inf_no_inv", reward_invincible, 1'b0);
    cyc();
    chk("inf_addtime_pulse", reward_addtime, 1'b0);
    ticks(8);
    mode_classic = 1'b1;
    ack(3'd1);
    grab();
    chk("cls_inv_on", reward_invincible, 1'b1);
    chk("cls_no_addtime", reward_addtime, 1'b0);
    chk("cls_remain20", remain_cnt, 6'd20);
    ticks(19);
    chk("cls_inv_19", reward_invincible, 1'b1);
    ticks(1);
    chk("cls_inv_off", reward_invincible, 1'b0);
    mode_classic = 1'b0; mode_infinity = 1'b0;

    ack(3'd4);
    grab();
    chk("laser_on", reward_laser, 1'b1);
    ticks(15);
    chk("laser_remain5", remain_cnt, 6'd5);
    ack(3'd4);
    grab();
    chk("laser_reload", remain_cnt, 6'd20);
    ticks(8);
    chk("laser_remain12", remain_cnt, 6'd12);
    ack(3'd3);
    grab();
    chk("frozen_on", reward_frozen, 1'b1);
    chk("laser_still_on", reward_laser, 1'b1);
    chk("remain_frozen", remain_cnt, 6'd20);
    ticks(1);
    chk("remain_frozen19", remain_cnt, 6'd19);

    ticks(7);
    chk("edge_req", spawn_req, 1'b1);
    ack(3'd2);
    ticks(39);
    chk("edge_prev_fast_off", reward_faster, 1'b0);
    tick = 1'b1; pickup = 1'b1;
    cyc();
    tick = 1'b0; pickup = 1'b0;
    chk("edge_pick_grant", reward_faster, 1'b1);
    chk("edge_pick_taken", reward_taken, 1'b1);

    enable = 1'b0;
    cyc();
    chk("dis_outputs", {25'd0, fx()}, 32'd0);
    chk("dis_remain", remain_cnt, 6'd0);
    enable = 1'b1;
    grab();
    chk("pick_cooldown_ignored", {25'd0, fx()}, 32'd0);
    ticks(8);
    chk("reen_req", spawn_req, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_req", spawn_req, 1'b0);
    cyc();
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/reward_scheduler.md
Name: reward_scheduler

Overview:
Sequences the reward subsystem. Paces spawn requests to the reward random generator through a req/ack handshake and tracks whether a reward is on the map. Converts tank pickups into effect grants and owns one independent duration timer per timed effect, replacing the single shared effect counter. Sits between the game-mode control, the reward generator and the reward display/information blocks.

Parameters:
DURATION, 20, effect length in ticks (5 s at 4 Hz); must be ≤ 2^CNT_W-1
SPAWN_GAP, 8, ticks between reward removal/expiry and the next spawn request
LIFETIME, 40, ticks an unclaimed reward stays on the map
CNT_W, 6, width of all tick counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-clk-cycle pulse at 4 Hz, synchronous to clk
enable  in  1  reward subsystem enable; low = synchronous clear
mode_classic  in  1  classic game mode
mode_infinity  in  1  infinity game mode
spawn_req  out  1  request the generator to place a new reward
spawn_ack  in  1  one-cycle pulse: reward placed, spawn_type valid
spawn_type  in  3  type of the placed reward (1 inv/addtime, 2 faster, 3 frozen, 4 laser)
pickup  in  1  one-cycle pulse: tank cell equals reward cell
reward_valid  out  1  a reward is on the map
reward_taken  out  1  one-cycle pulse to the generator: reward consumed/expired, clear position
reward_invincible  out  1  effect active
reward_addtime  out  1  one-cycle pulse, add time (infinity mode)
reward_faster  out  1  effect active
reward_frozen  out  1  effect active
reward_laser  out  1  effect active
remain_cnt  out  CNT_W  remaining ticks of the most recently granted timed effect

Behaviour:
- Reset (rst_n=0, async): FSM=COOLDOWN with gap counter=SPAWN_GAP; all timers 0; all outputs 0; last_type=0.
- enable=0: same state as reset, applied synchronously on the next clk edge; held while low.
- FSM states: COOLDOWN, REQUEST, PLACED.
- COOLDOWN: gap counter decrements on tick. When it reaches 0 → REQUEST.
- REQUEST: spawn_req=1, registered, held until spawn_ack. On the spawn_ack cycle, latch spawn_type into cur_type and spawn_req drops the next cycle.
  - cur_type in 1..4: → PLACED, life counter=LIFETIME, reward_valid=1.
  - Otherwise: discard, reward_taken pulse, → COOLDOWN.
- PLACED: life counter decrements on tick.
  - pickup: grant cur_type, reward_taken pulse, reward_valid=0, gap counter=SPAWN_GAP, → COOLDOWN.
  - Life counter reaches 0: same exit without a grant.
  - pickup and the expiring tick in the same cycle: pickup wins, grant issued.
- pickup outside PLACED is ignored.
- Grant, registered, one cycle after pickup:
  - Type 1 with mode_classic: load inv timer.
  - Type 1 with mode_infinity: one-cycle reward_addtime pulse.
  - Type 1 with both modes high: classic wins.
  - Type 1 with neither mode: no effect.
  - Type 2/3/4: load the faster/frozen/laser timer.
- Timers: four independent down-counters. Load DURATION on grant and decrement by 1 on tick while nonzero; each effect output is high exactly while its timer ≠ 0.
  - Re-grant of an active type reloads to DURATION; effects do not stack.
  - Load and tick in the same cycle: load wins.
  - Different effects run concurrently.
- last_type updates on every timed grant. remain_cnt = timer[last_type], or 0 if none has been granted.
- Latencies: spawn_ack → reward_valid 1 cycle; pickup → effect high 1 cycle.

Decomposition:
- Shared package reward_pkg: type codes REW_NONE=0, REW_INV=1, REW_FAST=2, REW_FROZEN=3, REW_LASER=4; FSM state encoding.
- Sub-module reward_effect_timer (load, tick, clear, count out, active out), instantiated 4 times.

Test Plan:
- Reset release with enable=1: 8 ticks → spawn_req rises after the 8th tick; spawn_ack with type 3 → reward_valid=1 next cycle, spawn_req=0.
- PLACED type 2, pickup → reward_faster=1 next cycle, reward_taken pulse; stays high exactly 20 ticks; remain_cnt counts 20→0.
- No pickup: after 40 ticks → reward_taken, reward_valid=0; no effect asserted; next spawn_req 8 ticks later.
- Type 1, mode_infinity=1: pickup → single-cycle reward_addtime, reward_invincible stays 0. With mode_classic=1: invincible held for 20 ticks.
- Laser active with 5 ticks left, new laser pickup → timer back to 20. Frozen granted meanwhile → both high; remain_cnt follows frozen.
- Edge cases: spawn_ack type 0 → immediate COOLDOWN, no reward_valid. pickup on the expiry tick → grant issued. enable dropped mid-effect → all outputs 0 next cycle. rst_n asserted mid-REQUEST → spawn_req 0 immediately (async).
